// File: rtl/fp_pkg.sv
// Shared constants and types for the IEEE-754 single to signed Q16.16 converter.
`timescale 1ns/1ps
package fp_pkg;

    localparam int EXP_BIAS  = 127;
    localparam int FRAC_BITS = 16;

    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    // Unbiased exponent landmarks: the 24-bit significand carries 23 fraction
    // bits, so it lines up with Q16.16 when shifted by (e - E_PIVOT).
    localparam logic signed [8:0] E_PIVOT = 9'(23 - FRAC_BITS);
    localparam logic signed [8:0] E_SAT   = 9'sd15;
    localparam logic signed [8:0] E_UFL   = -9'sd16;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic                sign;
        logic signed [8:0]   exp;
        logic        [23:0]  sig;
        fp_class_e           cls;
    } fp_fields_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational field split and classification of an IEEE-754 single word.
`timescale 1ns/1ps
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] i_data,
    output fp_fields_t  o_fields
);

    logic [7:0]  w_exp_raw;
    logic [22:0] w_mant;

    assign w_exp_raw = i_data[30:23];
    assign w_mant    = i_data[22:0];

    always_comb begin
        o_fields      = '0;
        o_fields.sign = i_data[31];
        o_fields.exp  = $signed({1'b0, w_exp_raw}) - 9'(EXP_BIAS);
        o_fields.sig  = {1'b1, w_mant};
        if (w_exp_raw == 8'd0) begin
            o_fields.cls = ZERO;
        end else if (w_exp_raw == 8'hFF) begin
            o_fields.cls = (w_mant != 23'd0) ? NAN : INF;
        end else begin
            o_fields.cls = NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_fixed_decoder.sv
// Two-stage IEEE-754 single to signed Q16.16 converter with valid/ready flow control.
`timescale 1ns/1ps
module fp_to_fixed_decoder
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_nan
);

    // Handshake: a word moves across a port on any rising edge where valid and
    // ready are both high; a stage reloads when empty or when it is being drained.
    fp_fields_t  w_fields;
    fp_fields_t  r_s1;
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic [31:0] r_s2_data;
    logic        r_s2_ovf;
    logic        r_s2_nan;

    logic        w_s2_load;
    logic        w_s1_load;
    logic [4:0]  w_shl;
    logic [4:0]  w_shr;
    logic [31:0] w_mag;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_nan;

    fp_unpack u_unpack (
        .i_data   (in_data),
        .o_fields (w_fields)
    );

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_ovf   = r_s2_ovf;
    assign out_nan   = r_s2_nan;

    assign w_shl = r_s1.exp[4:0] - E_PIVOT[4:0];
    assign w_shr = E_PIVOT[4:0] - r_s1.exp[4:0];

    always_comb begin
        w_mag = '0;
        w_res = '0;
        w_ovf = 1'b0;
        w_nan = 1'b0;
        case (r_s1.cls)
            NAN: w_nan = 1'b1;
            INF: begin
                w_ovf = 1'b1;
                w_res = r_s1.sign ? Q_MIN : Q_MAX;
            end
            NORMAL: begin
                if (r_s1.exp < E_UFL) begin
                    w_res = '0;
                end else if (!r_s1.sign && r_s1.exp >= E_SAT) begin
                    w_ovf = 1'b1;
                    w_res = Q_MAX;
                end else if (r_s1.sign && (r_s1.exp > E_SAT ||
                             (r_s1.exp == E_SAT && r_s1.sig[22:0] != 23'd0))) begin
                    w_ovf = 1'b1;
                    w_res = Q_MIN;
                end else if (r_s1.exp == E_SAT) begin
                    // Exactly -32768.0 is representable, so no saturation flag.
                    w_res = Q_MIN;
                end else begin
                    if (r_s1.exp >= E_PIVOT) begin
                        w_mag = {8'd0, r_s1.sig} << w_shl;
                    end else begin
                        w_mag = {8'd0, r_s1.sig} >> w_shr;
                    end
                    w_res = r_s1.sign ? (~w_mag + 32'd1) : w_mag;
                end
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1 <= w_fields;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= 1'b0;
            r_s2_nan   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_ovf  <= w_ovf;
                r_s2_nan  <= w_nan;
            end
        end
    end

endmodule

// File: tb/tb_fp_to_fixed_decoder.sv
// Directed and random checks of fp_to_fixed_decoder against a real-arithmetic model.
`timescale 1ns/1ps
module tb_fp_to_fixed_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_nan;

    // Expected entries are {ovf, nan, data}.
    logic [33:0] exp_q[$];
    int          n_vec;
    int          n_fail;
    logic        rand_done;

    fp_to_fixed_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact real value of the float times 2^16, truncated toward zero.
    function automatic logic [33:0] model(input logic [31:0] w);
        logic        s;
        int          ex;
        int          mant;
        real         v;
        int          m;
        logic [31:0] r;
        s    = w[31];
        ex   = int'(w[30:23]);
        mant = int'(w[22:0]);
        if (ex == 0) return 34'd0;
        if (ex == 255) begin
            if (mant != 0) return {2'b01, 32'd0};
            return {2'b10, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        end
        v = (1.0 + real'(mant) / 8388608.0) * 65536.0;
        for (int i = 0; i < ex - 127; i++) v = v * 2.0;
        for (int i = 0; i < 127 - ex; i++) v = v / 2.0;
        if (!s && v >= 2147483648.0) return {2'b10, 32'h7FFF_FFFF};
        if (s && v > 2147483648.0) return {2'b10, 32'h8000_0000};
        if (s && v == 2147483648.0) return {2'b00, 32'h8000_0000};
        m = $rtoi(v);
        r = s ? 32'(-m) : 32'(m);
        return {2'b00, r};
    endfunction

    // driver tasks
    task automatic send_exp(input logic [31:0] w, input logic [33:0] expv);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {33'd0, in_ready}, 34'd1);
        end else begin
            exp_q.push_back(expv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        send_exp(w, model(w));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", 34'(exp_q.size()), 34'd0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {33'd0, out_valid}, 34'd0);
            end else begin
                chk("out_word", {out_ovf, out_nan, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        rand_done = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
        chk("rst_out_word", {out_ovf, out_nan, out_data}, 34'd0);
        chk("rst_in_ready", {33'd0, in_ready}, 34'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 with latency check: out_valid rises on the second edge after accept
        send_exp(32'h3F80_0000, {2'b00, 32'h0001_0000});
        chk("lat_edge1", {33'd0, out_valid}, 34'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", {33'd0, out_valid}, 34'd1);
        drain();

        // directed corner values
        send_exp(32'hC020_0000, {2'b00, 32'hFFFD_8000});
        send_exp(32'h3780_0000, {2'b00, 32'h0000_0001});
        send_exp(32'h3700_0000, {2'b00, 32'h0000_0000});
        send_exp(32'h4700_0000, {2'b10, 32'h7FFF_FFFF});
        send_exp(32'hC700_0000, {2'b00, 32'h8000_0000});
        send_exp(32'hC700_0001, {2'b10, 32'h8000_0000});
        send_exp(32'hFF80_0000, {2'b10, 32'h8000_0000});
        send_exp(32'h7F80_0000, {2'b10, 32'h7FFF_FFFF});
        send_exp(32'h7FC0_0000, {2'b01, 32'h0000_0000});
        send_exp(32'h8000_0000, {2'b00, 32'h0000_0000});
        send_exp(32'h0000_0001, {2'b00, 32'h0000_0000});
        send_exp(32'h46FF_FFFF, {2'b00, 32'h7FFF_FF80});
        send_exp(32'hC6FF_FFFF, {2'b00, 32'h8000_0080});
        drain();

        // stall: two accepts fill the pipe, third word waits, output held
        out_ready = 1'b0;
        send_exp(32'h3F80_0000, {2'b00, 32'h0001_0000});
        send_exp(32'h4000_0000, {2'b00, 32'h0002_0000});
        in_valid = 1'b1;
        in_data  = 32'h4040_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {33'd0, in_ready}, 34'd0);
            chk("stall_out_valid", {33'd0, out_valid}, 34'd1);
            chk("stall_hold", {out_ovf, out_nan, out_data}, {2'b00, 32'h0001_0000});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_exp(32'h4040_0000, {2'b00, 32'h0003_0000});
        drain();

        // random words under random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (i < 30) send({1'($urandom_range(0, 1)), 8'($urandom_range(105, 145)),
                                      23'($urandom_range(0, 32'h7F_FFFF))});
                    else        send($urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with two words in flight discards them
        out_ready = 1'b0;
        send(32'h3F80_0000);
        send(32'h4000_0000);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {33'd0, out_valid}, 34'd0);
        chk("midrst_in_ready", {33'd0, in_ready}, 34'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {33'd0, out_valid}, 34'd0);
        end
        @(posedge clk);
        #1;
        send_exp(32'hBF80_0000, {2'b00, 32'hFFFF_0000});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_to_fixed_decoder.md
FP_TO_FIXED_DECODER -- requirements
Module: fp_to_fixed_decoder

Interface
REQ-001 Parameters: none; output format is fixed signed Q16.16 (16 integer bits incl. sign, 16 fraction bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data holds a word to convert.
REQ-005 in_ready  output  1  decoder accepts in_data this cycle.
REQ-006 in_data  input  32  IEEE-754 single {sign, exp[7:0], mantissa[22:0]}.
REQ-007 out_valid  output  1  out_data/flags valid.
REQ-008 out_ready  input  1  downstream consumes output this cycle.
REQ-009 out_data  output  32  signed Q16.16 result, two's complement.
REQ-010 out_ovf  output  1  result saturated (overflow or infinity).
REQ-011 out_nan  output  1  input was NaN.

Function
REQ-012 Transfer on in_valid && in_ready (input) and out_valid && out_ready (output); data never dropped or duplicated; order preserved.
REQ-013 Two-stage pipeline: S1 registers unpack/classify (sign, e = exp-127, 24-bit significand {1,mantissa}, class); S2 registers shift, negate, saturate result.
REQ-014 Latency 2 cycles input-accept to out_valid when unstalled; throughput 1 word/cycle.
REQ-015 Each stage loads when empty or when its content is moved on this cycle; in_ready = !S1_valid || S1 advances; in_ready combinational from out_ready only through that term.
REQ-016 With out_valid high and out_ready low, out_data/out_ovf/out_nan hold stable.
REQ-017 Magnitude = significand shifted left by (e-7) if e>=7, else right by (7-e), truncated (round toward zero); then negated if sign=1.
REQ-018 exp==0 (zero, denormal): out_data=0, flags 0.
REQ-019 Underflow e < -16: out_data=0, flags 0.
REQ-020 Positive with e >= 15 or +Inf: out_data=0x7FFFFFFF, out_ovf=1.
REQ-021 Negative with e > 15, or e==15 and mantissa!=0, or -Inf: out_data=0x80000000, out_ovf=1; exactly -32768.0 (0xC7000000) gives 0x80000000, out_ovf=0.
REQ-022 NaN (exp==255, mantissa!=0): out_data=0, out_nan=1, out_ovf=0.
REQ-023 -0.0 (0x80000000) gives 0x00000000.
REQ-024 Simultaneous accept and emit in same cycle with both stages full: pipeline shifts, no bubble.

Reset
REQ-025 rst_n low: S1_valid=0, S2_valid=0, out_valid=0, out_data=0, out_ovf=0, out_nan=0, in_ready=1 after reset value settles.
REQ-026 Reset mid-operation discards all in-flight words; no output after release until new input accepted.
REQ-027 Reset release takes effect only at the next clk edge; first accept possible the cycle after release.

Structure
REQ-028 Shared package fp_pkg holds EXP_BIAS=127, FRAC_BITS=16, Q_MAX=0x7FFFFFFF, Q_MIN=0x80000000 and class enum {ZERO, NORMAL, INF, NAN}.
REQ-029 One sub-module fp_unpack (combinational S1 classify/field split); S1/S2 registers and handshake stay in the top module.
REQ-030 No latches; all registers reset by rst_n.

Verification
REQ-031 0x3F800000 (1.0), out_ready=1 -> out_data=0x00010000 two cycles later, flags 0.
REQ-032 0xC0200000 (-2.5) -> 0xFFFD8000; 0x37800000 (2^-16) -> 0x00000001; 0x37000000 (2^-17) -> 0x00000000.
REQ-033 0x47000000 (32768.0) -> 0x7FFFFFFF ovf=1; 0xC7000000 -> 0x80000000 ovf=0; 0xFF800000 (-Inf) -> 0x80000000 ovf=1.
REQ-034 0x7FC00000 (NaN) -> out_data=0, out_nan=1.
REQ-035 Back-to-back 1.0, 2.0, 3.0 with out_ready low 4 cycles -> in_ready low after two accepts, output held; after release 0x00010000, 0x00020000, 0x00030000 in order.
REQ-036 rst_n pulsed low with two words in flight -> out_valid=0 immediately, no stale word emitted after release.
